// File: rtl/instruction_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_fetch_sequencer
//
// Steps a program counter through an instruction memory that has combinational
// read data. Each word is fetched in one cycle and then offered downstream with
// a valid/ready handshake. The program ends on one of two conditions:
//   - an all-ones word (END_OF_PROGRAM) is read, or
//   - the word at the last address is handed off. In this case the overflow
//     flag is set and the counter does not wrap.
//
// Parameters
//   DATA_BUS_WIDTH     width of one instruction word (default 16)
//   ADDRESS_BUS_WIDTH  width of the instruction memory address (default 8)
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle pulse; starts execution at address 0 (IDLE/DONE only)
//   abort        level; returns to IDLE, overrides start and any handshake
//   mem_address  instruction memory address (registered program counter)
//   mem_enable   instruction memory read enable (high only while fetching)
//   mem_data     combinational read data from instruction memory
//   instr_data   issued instruction word (registered)
//   instr_valid  instr_data is valid
//   instr_ready  downstream accepts instr_data
//   busy         high while fetching or issuing
//   done         high only in DONE
//   overflow     last address was issued and the program ran off the end
//   instr_count  (only with INSTR_COUNT_EN defined) completed handshakes since
//                the last start; cleared by reset, start and abort
//
// Optional feature macro: INSTR_COUNT_EN
// -----------------------------------------------------------------------------
module instruction_fetch_sequencer #(
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int ADDRESS_BUS_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
    output logic                         mem_enable,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_data,
    output logic [DATA_BUS_WIDTH-1:0]    instr_data,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
`ifdef INSTR_COUNT_EN
    ,
    output logic [ADDRESS_BUS_WIDTH:0]   instr_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDRESS_BUS_WIDTH-1:0] PC_MAX = {ADDRESS_BUS_WIDTH{1'b1}};
    localparam logic [DATA_BUS_WIDTH-1:0]    END_OF_PROGRAM = {DATA_BUS_WIDTH{1'b1}};

    state_t                        state_reg;
    logic [ADDRESS_BUS_WIDTH-1:0]  pc_reg;
    logic [DATA_BUS_WIDTH-1:0]     instr_data_reg;
    logic                          instr_valid_reg;
    logic                          mem_enable_reg;
    logic                          busy_reg;
    logic                          done_reg;
    logic                          overflow_reg;

    // The status flags are registered together with the state. Each transition
    // below sets them to the values of the state it enters, so the outputs
    // always match state_reg without any output decode logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            instr_data_reg  <= '0;
            instr_valid_reg <= 1'b0;
            mem_enable_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
        end else if (abort) begin
            // Abort wins over start and over a handshake on the same edge.
            // The counter is cleared rather than advanced.
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            instr_valid_reg <= 1'b0;
            mem_enable_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg      <= S_FETCH;
                        pc_reg         <= '0;
                        mem_enable_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        overflow_reg   <= 1'b0;
                    end
                end

                S_FETCH: begin
                    mem_enable_reg <= 1'b0;
                    if (mem_data == END_OF_PROGRAM) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg       <= S_ISSUE;
                        instr_data_reg  <= mem_data;
                        instr_valid_reg <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    // instr_valid_reg is always high in ISSUE, so instr_ready
                    // alone decides whether the handshake completes.
                    if (instr_ready) begin
                        instr_valid_reg <= 1'b0;
                        if (pc_reg == PC_MAX) begin
                            // The counter stays at the last address and does not wrap.
                            state_reg    <= S_DONE;
                            overflow_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                        end else begin
                            state_reg      <= S_FETCH;
                            pc_reg         <= pc_reg + 1'b1;
                            mem_enable_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_address = pc_reg;
    assign mem_enable  = mem_enable_reg;
    assign instr_data  = instr_data_reg;
    assign instr_valid = instr_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign overflow    = overflow_reg;

`ifdef INSTR_COUNT_EN
    // The counter needs one bit more than the address, so a full 2^N-word run
    // still fits.
    logic [ADDRESS_BUS_WIDTH:0] instr_count_reg;
    logic                       handshake;
    logic                       restart;

    assign handshake = (state_reg == S_ISSUE) && instr_ready;
    assign restart   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    always_ff @(posedge clk) begin
        if (reset || abort || restart) begin
            instr_count_reg <= '0;
        end else if (handshake) begin
            instr_count_reg <= instr_count_reg + 1'b1;
        end
    end

    assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for instruction_fetch_sequencer (DATA=16, ADDR=8).
//
// The first part is a per-cycle vector table for a short program, a restart
// from DONE and abort priority. Hand-written sequences then cover:
//   - backpressure
//   - an immediate END_OF_PROGRAM
//   - a full-memory run that ends in overflow
//   - an abort on the same edge as a handshake
//   - a reset while in ISSUE
//
// A combinational memory model drives mem_data. Outputs are sampled 1 ns after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_sequencer;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] mem_address;
    logic          mem_enable;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] instr_data;
    logic          instr_valid;
    logic          instr_ready;
    logic          busy;
    logic          done;
    logic          overflow;
`ifdef INSTR_COUNT_EN
    logic [AW:0]   instr_count;
`endif

    logic [DW-1:0] mem [256];
    assign mem_data = mem[mem_address];

    int n_cmp;
    int n_err;

    instruction_fetch_sequencer #(
        .DATA_BUS_WIDTH    (DW),
        .ADDRESS_BUS_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .mem_address (mem_address),
        .mem_enable  (mem_enable),
        .mem_data    (mem_data),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle vector: inputs applied before the edge, outputs expected after it.
    typedef struct {
        logic          start;
        logic          abort;
        logic          ready;
        logic          v;
        logic          e;
        logic          b;
        logic          d;
        logic          o;
        logic [AW-1:0] a;
        logic [DW-1:0] dt;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic s, input logic ab, input logic r,
                                input logic v, input logic e, input logic b,
                                input logic d, input logic o,
                                input logic [AW-1:0] a, input logic [DW-1:0] dt);
        vec_t x;
        x.start = s;  x.abort = ab; x.ready = r;
        x.v = v; x.e = e; x.b = b; x.d = d; x.o = o;
        x.a = a; x.dt = dt;
        return x;
    endfunction

    // Packed layout: {3'b0, valid, enable, busy, done, overflow, addr, data}
    function automatic logic [31:0] pack(input logic v, input logic e, input logic b,
                                         input logic d, input logic o,
                                         input logic [AW-1:0] a, input logic [DW-1:0] dt);
        return {3'b000, v, e, b, d, o, a, dt};
    endfunction

    function automatic logic [31:0] observed();
        return pack(instr_valid, mem_enable, busy, done, overflow, mem_address, instr_data);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_prog4();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0008; mem[1] = 16'h0005; mem[2] = 16'h0003; mem[3] = 16'hFFFF;
    endtask

    initial begin
        int issues;
        int k;
        logic found;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; instr_ready = 1'b0;
        load_prog4();

        // ---- reset state ----
        do_reset();
        check("reset_state", observed(), pack(L, L, L, L, L, 8'h00, 16'h0000));

        // ---- table: program {8,5,3,FFFF}, ready=1, then restart and abort ----
        tbl[0]  = mk(H, L, H,  L, H, H, L, L, 8'h00, 16'h0000); // start -> FETCH @0
        tbl[1]  = mk(L, L, H,  H, L, H, L, L, 8'h00, 16'h0008); // ISSUE 0008
        tbl[2]  = mk(L, L, H,  L, H, H, L, L, 8'h01, 16'h0008); // handshake -> FETCH @1
        tbl[3]  = mk(L, L, H,  H, L, H, L, L, 8'h01, 16'h0005);
        tbl[4]  = mk(L, L, H,  L, H, H, L, L, 8'h02, 16'h0005);
        tbl[5]  = mk(L, L, H,  H, L, H, L, L, 8'h02, 16'h0003);
        tbl[6]  = mk(L, L, H,  L, H, H, L, L, 8'h03, 16'h0003);
        tbl[7]  = mk(L, L, H,  L, L, L, H, L, 8'h03, 16'h0003); // FFFF -> DONE
        tbl[8]  = mk(L, L, H,  L, L, L, H, L, 8'h03, 16'h0003); // DONE holds
        tbl[9]  = mk(H, L, H,  L, H, H, L, L, 8'h00, 16'h0003); // restart from DONE
        tbl[10] = mk(L, H, H,  L, L, L, L, L, 8'h00, 16'h0003); // abort in FETCH -> IDLE
        tbl[11] = mk(H, H, H,  L, L, L, L, L, 8'h00, 16'h0003); // abort beats start

        for (int i = 0; i < 12; i++) begin
            start       = tbl[i].start;
            abort       = tbl[i].abort;
            instr_ready = tbl[i].ready;
            step();
            check($sformatf("vec%0d", i), observed(),
                  pack(tbl[i].v, tbl[i].e, tbl[i].b, tbl[i].d, tbl[i].o, tbl[i].a, tbl[i].dt));
`ifdef INSTR_COUNT_EN
            if (i == 8) check("vec8_count", 32'(instr_count), 32'd3);
`endif
        end
        start = 1'b0; abort = 1'b0;

        // ---- backpressure: {8,FFFF}, ready low for 5 cycles ----
        do_reset();
        load_prog4();
        mem[1] = 16'hFFFF;
        instr_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;   // FETCH @0
        step();                               // ISSUE 0008
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);                 // start must be ignored in ISSUE
            step();
            check($sformatf("bp_hold%0d", i), observed(),
                  pack(H, L, H, L, L, 8'h00, 16'h0008));
        end
        start = 1'b0;
        instr_ready = 1'b1;
        step();
        check("bp_advance", observed(), pack(L, H, H, L, L, 8'h01, 16'h0008));
        step();
        check("bp_done", observed(), pack(L, L, L, H, L, 8'h01, 16'h0008));
`ifdef INSTR_COUNT_EN
        check("bp_count", 32'(instr_count), 32'd1);
`endif

        // ---- immediate END_OF_PROGRAM ----
        do_reset();
        mem[0] = 16'hFFFF;
        start = 1'b1; step(); start = 1'b0;
        check("eop_fetch", observed(), pack(L, H, H, L, L, 8'h00, 16'h0000));
        step();
        check("eop_done", observed(), pack(L, L, L, H, L, 8'h00, 16'h0000));
`ifdef INSTR_COUNT_EN
        check("eop_count", 32'(instr_count), 32'd0);
`endif

        // ---- full memory of 0001 -> 256 issues then overflow ----
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
        instr_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        issues = 0;
        k = 0;
        while (!done && k < 700) begin
            step();
            if (instr_valid) issues++;
            k++;
        end
        check("ovf_issues", 32'(issues), 32'd256);
        check("ovf_final", observed(), pack(L, L, L, H, H, 8'hFF, 16'h0001));
`ifdef INSTR_COUNT_EN
        check("ovf_count", 32'(instr_count), 32'd256);
`endif
        // Reset from DONE with overflow set clears every flag.
        reset = 1'b1; step(); reset = 1'b0;
        check("ovf_reset", observed(), pack(L, L, L, L, L, 8'h00, 16'h0000));

        // ---- abort on the same edge as the handshake of address 2 ----
        do_reset();
        load_prog4();
        instr_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (instr_valid && mem_address == 8'h02) found = 1'b1;
        end
        check("abort_reach_addr2", 32'(found), 32'd1);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_idle", observed(), pack(L, L, L, L, L, 8'h00, 16'h0003));
        start = 1'b1; step(); start = 1'b0;
        check("abort_refetch", observed(), pack(L, H, H, L, L, 8'h00, 16'h0003));
        step();
        check("abort_reissue", observed(), pack(H, L, H, L, L, 8'h00, 16'h0008));

        // ---- reset while in ISSUE ----
        instr_ready = 1'b0;
        step();
        check("rst_in_issue_pre", observed(), pack(H, L, H, L, L, 8'h00, 16'h0008));
        reset = 1'b1; start = 1'b1; instr_ready = 1'b1;  // reset beats start and handshake
        step();
        reset = 1'b0; start = 1'b0;
        check("rst_in_issue", observed(), pack(L, L, L, L, L, 8'h00, 16'h0000));
        start = 1'b1; step(); start = 1'b0;
        check("rst_restart_fetch", observed(), pack(L, H, H, L, L, 8'h00, 16'h0000));
        step();
        check("rst_restart_issue", observed(), pack(H, L, H, L, L, 8'h00, 16'h0008));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
